uart_rx_frame: RTL and testbench
================================

Name: uart_rx_frame

Overview:
Receive side of the team's 8N1 UART link. It pairs with the existing transmit state machine and its 9600-baud generator. The block samples the serial line on the 100 MHz fabric clock and rebuilds each byte (start bit, 8 data bits LSB-first, stop bit). It holds the byte in a one-deep output register with a valid/ack handshake and reports framing and overrun errors. It sits between the board RX pin and the report/BRAM write path.

Parameters:
- CLKS_PER_BIT, 10418, fabric clocks per bit. This matches the transmitter's bit time: 2*(5208+1). Must be ≥ 8.
- CNT_W, 16, width of the bit-timing counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk, in, 1, fabric clock (100 MHz).
- rst, in, 1, reset. Asynchronous, active-high.
- rx, in, 1, raw serial line. Asynchronous to clk; idles high.
- rx_ack, in, 1, consumer accepts rx_data. Clears rx_valid.
- err_clr, in, 1, clears the sticky error flags.
- rx_data, out, 8, last received byte.
- rx_valid, out, 1, rx_data holds an unconsumed byte (level signal).
- busy, out, 1, a frame is in progress (state ≠ IDLE).
- frame_err, out, 1, sticky: stop bit sampled low.
- overrun_err, out, 1, sticky: a byte completed while rx_valid=1 and rx_ack=0.

Behaviour:
- Reset values: rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, overrun_err=0, state=IDLE, counters=0, synchronizer flops=1.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so line-to-decision latency is 2 clocks.
- State machine: IDLE → START → DATA → STOP → IDLE. A failed stop bit routes STOP → BREAK instead.
- IDLE: when rx_s=0, clear the timing counter and go to START.
- START: wait CLKS_PER_BIT/2 clocks (integer division), then sample.
  - rx_s=0: reset the counter and bit index, go to DATA.
  - rx_s=1: glitch. Return to IDLE with no flags raised.
- DATA: sample every CLKS_PER_BIT clocks into shift register bit [idx], LSB first. After idx=7 is sampled, go to STOP.
- STOP: after CLKS_PER_BIT clocks, sample.
  - rx_s=1: deliver the byte. Go to IDLE.
  - rx_s=0: set frame_err, discard the byte, go to BREAK.
- BREAK: stay until rx_s=1, then go to IDLE. This stops a held-low line from retriggering.
- Delivery: rx_data and rx_valid update on the clock after the stop-bit sample.
- rx_valid clears on any cycle where rx_ack=1. rx_ack while rx_valid=0 has no effect.
- Byte completes on the same cycle as rx_ack: load the new byte; rx_valid stays 1; no overrun.
- Byte completes while rx_valid=1 and rx_ack=0: drop the new byte, keep the old rx_data, set overrun_err.
- err_clr clears both sticky flags. If a flag's set condition occurs on the same cycle, set wins.
- Reset mid-frame: aborts immediately to IDLE, all outputs at reset values.
- Counter increments saturate-free. It is reloaded to 0 at every sample point, so it cannot wrap.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit CLKS_PER_BIT after the last data bit. A new sticky output, parity_err (1 bit, reset 0, cleared by err_clr), is set if XOR(data, parity bit) ≠ 0. The byte is still delivered when parity fails. Stop is sampled at 10*CLKS_PER_BIT after the start midpoint.
- Undefined: the PARITY state and the parity_err port do not exist. Behaviour is exactly 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4, BREAK=3'd5;
  - DATA_BITS=8;
  - the default CLKS_PER_BIT=10418, so TX and RX share one bit time.
- One sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1.

Test Plan (CLKS_PER_BIT=16 in the bench):
- 8'hA5 sent 8N1 → rx_valid rises one clock after the stop sample, rx_data=8'hA5, no flags set.
- Start pulse held low for 6 clocks, then line high → state returns to IDLE, busy falls, rx_valid=0, no flags set.
- 8'h3C sent with stop bit forced 0, line held low for 40 clocks → frame_err=1, rx_valid=0, state held in BREAK until the line goes high. Then 8'h11 is received correctly.
- 8'h01 then 8'h02 sent with no rx_ack → rx_data=8'h01, overrun_err=1. Then rx_ack → rx_valid=0. Then err_clr → overrun_err=0.
- rx_ack pulsed on the exact cycle 8'h7E completes → rx_data=8'h7E, rx_valid stays 1, overrun_err=0.
- rst asserted at data bit 4 of 8'hFF → all outputs at reset values. The next frame, 8'h5A, is received correctly. With UART_RX_PARITY_EN, 8'h07 with parity bit 0 gives parity_err=1 and the byte is still delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and the default bit time
// that the transmitter and receiver use.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 10418;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the raw RX pin. It resets to 1 (line idle), so the
// receiver never sees a false start bit coming out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver with a one-deep output register and sticky frame/overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra sticky parity_err output.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    rx_state_t            cur_state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] shreg;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign busy  = (cur_state != IDLE);
    assign state = cur_state;

    // Flag set/deliver assignments come after the clear assignments, so a
    // same-cycle set beats err_clr and a same-cycle delivery beats rx_ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state   <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            if (err_clr) begin
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err  <= 1'b0;
`endif
            end
            if (rx_ack) rx_valid <= 1'b0;

            case (cur_state)
                IDLE: begin
                    if (!rx_s) begin
                        cnt       <= '0;
                        cur_state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt       <= '0;
                        idx       <= '0;
                        cur_state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= rx_s;
                        idx        <= idx + 3'd1;
                        if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            cur_state <= PARITY;
`else
                            cur_state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (^{shreg, rx_s}) parity_err <= 1'b1;
                        cur_state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            if (rx_valid && !rx_ack) begin
                                overrun_err <= 1'b1;
                            end else begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end
                            cur_state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            cur_state <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s) cur_state <= IDLE;
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame at CLKS_PER_BIT=16: table of clean frames
// plus hand sequences for glitch, framing, overrun, same-cycle ack and reset.
module tb_uart_rx_frame;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // Line edge to rx_valid: 2 sync flops, 1 IDLE detect, half bit, then STOP_IDX bits.
    localparam int LAT = 3 + CPB / 2 + STOP_IDX * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;
    logic [2:0] state;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_frame #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_ack      (rx_ack),
        .err_clr     (err_clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .state       (state)
    );

    // ---------------- clock / reset / bookkeeping ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = -1;
    logic valid_d = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_d) rise_cyc <= cyc;
        valid_d <= rx_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; holds the line for n clocks.
    task automatic send_bits(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        start_cyc = cyc;
        send_bits(1'b0, CPB);
        for (int i = 0; i < 8; i++) send_bits(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        send_bits((^d) ^ par_flip, CPB);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bits(stop_bit, CPB);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 4 * CPB && !rx_valid; i++) @(negedge clk);
        check({name, "_valid"}, rx_valid, 1);
    endtask

    // Pops the scoreboard and compares against the delivered byte.
    task automatic score(input string name);
        logic [7:0] e;
        wait_valid(name);
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 1, 0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_data"}, rx_data, e);
        end
    endtask

    // ---------------- table of clean frames ----------------
    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'hA5, gap: 2,  exp_data: 8'hA5, exp_err: 1'b0};
        vecs[1] = '{data: 8'h00, gap: 0,  exp_data: 8'h00, exp_err: 1'b0};
        vecs[2] = '{data: 8'hFF, gap: 7,  exp_data: 8'hFF, exp_err: 1'b0};
        vecs[3] = '{data: 8'h5A, gap: 1,  exp_data: 8'h5A, exp_err: 1'b0};
        vecs[4] = '{data: 8'h81, gap: 13, exp_data: 8'h81, exp_err: 1'b0};
        vecs[5] = '{data: 8'h3C, gap: 4,  exp_data: 8'h3C, exp_err: 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", rx_data, 8'h00);
        check("rst_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_state", state, 0);
        rst = 1'b0;
        idle(4);

        // Clean frames: data, latency and no flags
        for (int v = 0; v < 6; v++) begin
            idle(vecs[v].gap + $urandom_range(0, 3));
            exp_q.push_back(vecs[v].exp_data);
            send_frame(vecs[v].data, 1'b1, 1'b0);
            score($sformatf("vec%0d", v));
            check($sformatf("vec%0d_latency", v), rise_cyc - start_cyc, LAT);
            check($sformatf("vec%0d_flags", v), {frame_err, overrun_err}, {2{vecs[v].exp_err}});
            pulse_ack();
            check($sformatf("vec%0d_acked", v), rx_valid, 0);
        end

        // Short start glitch
        send_bits(1'b0, 6);
        check("glitch_in_start", state, 3'd1);
        check("glitch_busy", busy, 1);
        send_bits(1'b1, 12);
        check("glitch_idle", state, 3'd0);
        check("glitch_not_busy", busy, 0);
        check("glitch_no_valid", rx_valid, 0);
        check("glitch_no_flags", {frame_err, overrun_err}, 0);

        // Bad stop bit with line held low, then recovery
        send_frame(8'h3C, 1'b0, 1'b0);
        send_bits(1'b0, 40);
        check("brk_frame_err", frame_err, 1);
        check("brk_no_valid", rx_valid, 0);
        check("brk_state", state, 3'd5);
        send_bits(1'b1, 8);
        check("brk_released", state, 3'd0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        score("after_brk");
        check("frame_err_sticky", frame_err, 1);
        pulse_ack();
        pulse_err_clr();
        check("frame_err_cleared", frame_err, 0);

        // Overrun: second byte dropped, first kept
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h02, 1'b1, 1'b0);
        idle(2);
        score("ovr");
        check("ovr_flag", overrun_err, 1);
        pulse_ack();
        check("ovr_ack_valid", rx_valid, 0);
        check("ovr_flag_sticky", overrun_err, 1);
        pulse_err_clr();
        check("ovr_cleared", overrun_err, 0);

        // rx_ack on the exact completion cycle of a new byte
        exp_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1'b0);
        score("pre_ack");
        exp_q.push_back(8'h7E);
        fork
            send_frame(8'h7E, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 rx_ack = 1'b1;
                @(posedge clk);
                #1 rx_ack = 1'b0;
            end
        join
        score("same_cycle_ack");
        check("same_cycle_valid", rx_valid, 1);
        check("same_cycle_no_ovr", overrun_err, 0);

        // Leave a byte and an overrun pending, then reset mid-frame
        send_frame(8'h44, 1'b1, 1'b0);
        idle(2);
        check("pre_rst_ovr", overrun_err, 1);
        send_bits(1'b0, CPB);
        for (int i = 0; i < 4; i++) send_bits(1'b1, CPB);
        rx = 1'b1;
        idle(8);
        check("mid_frame_state", state, 3'd2);
        rst = 1'b1;
        #2;
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_valid", rx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_flags", {frame_err, overrun_err}, 0);
        check("mid_rst_state", state, 3'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(5);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        score("post_rst");
        check("post_rst_latency", rise_cyc - start_cyc, LAT);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        // Wrong parity: flag raised, byte still delivered
        check("par_clean", parity_err, 0);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        score("parity");
        check("par_err", parity_err, 1);
        pulse_ack();
        pulse_err_clr();
        check("par_cleared", parity_err, 0);
`endif

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
